seq_priority_encoder: RTL and testbench

//  Parametrised successor to the 8-to-3 case encoder: a slice-serial priority encoder with valid/ready handshakes.

---
 rtl/encoder_pkg.sv | 24 ++
 rtl/slice_prio_enc.sv | 28 ++
 rtl/seq_priority_encoder.sv | 142 ++++++++++++++
 tb/tb_seq_priority_encoder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/encoder_pkg.sv
// Shared FSM encoding and width helpers for the slice-serial priority encoder.
package encoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

    // Index width that never collapses to zero bits.
    function automatic int unsigned idx_w(input int unsigned v);
        return (v > 1) ? clog2(v) : 1;
    endfunction

endpackage

// File: rtl/slice_prio_enc.sv
// Combinational priority encoder for one SLICE_W-bit slice, direction selectable.
module slice_prio_enc
    import encoder_pkg::*;
#(
    parameter int unsigned SLICE_W = 8,
    localparam int unsigned POS_W  = idx_w(SLICE_W)
) (
    input  logic [SLICE_W-1:0] slice,
    input  logic               msb_first,
    output logic [POS_W-1:0]   pos,
    output logic               nz,
    output logic               multi
);

    always_comb begin
        pos   = '0;
        nz    = |slice;
        multi = (slice & (slice - SLICE_W'(1))) != '0;
        // Ascending scan keeps the highest set bit, descending keeps the lowest.
        for (int i = 0; i < int'(SLICE_W); i++) begin
            if (msb_first && slice[i]) pos = POS_W'(i);
        end
        for (int i = int'(SLICE_W) - 1; i >= 0; i--) begin
            if (!msb_first && slice[i]) pos = POS_W'(i);
        end
    end

endmodule

// File: rtl/seq_priority_encoder.sv
// Slice-serial priority encoder: captures a word, scans SLICE_W bits per cycle,
// reports winning index plus any/multi flags over a valid/ready handshake.
module seq_priority_encoder
    import encoder_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned SLICE_W = 8,
    localparam int unsigned CODE_W = clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              msb_first,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_code,
    output logic              out_any,
    output logic              out_multi
);

    localparam int unsigned NSLICE = DATA_W / SLICE_W;
    localparam int unsigned CNT_W  = idx_w(NSLICE);
    localparam int unsigned POS_W  = idx_w(SLICE_W);

    state_t              state, state_d;
    logic [DATA_W-1:0]   word, word_d;
    logic                msb_q, msb_d;
    logic [CNT_W-1:0]    cnt, cnt_d;
    logic                found, found_d;
    logic [CODE_W-1:0]   code_acc, code_d;
    logic                any_acc, any_d;
    logic                multi_acc, multi_d;
    logic                out_valid_d;
    logic [CODE_W-1:0]   out_code_d;
    logic                out_any_d, out_multi_d;

    logic [CNT_W-1:0]    sidx_c;
    logic [SLICE_W-1:0]  cur_slice_c;
    logic [POS_W-1:0]    pos_c;
    logic                nz_c, smulti_c;
    logic [CODE_W-1:0]   win_code_c;

    // MSB mode walks slices from the top down, LSB mode from the bottom up.
    assign sidx_c      = msb_q ? (CNT_W'(NSLICE - 1) - cnt) : cnt;
    assign cur_slice_c = SLICE_W'(word >> (int'(sidx_c) * int'(SLICE_W)));
    assign win_code_c  = CODE_W'(int'(sidx_c) * int'(SLICE_W) + int'(pos_c));
    assign in_ready    = (state == ST_IDLE) && !rst;

    slice_prio_enc #(.SLICE_W(SLICE_W)) u_slice (
        .slice     (cur_slice_c),
        .msb_first (msb_q),
        .pos       (pos_c),
        .nz        (nz_c),
        .multi     (smulti_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            word      <= '0;
            msb_q     <= 1'b0;
            cnt       <= '0;
            found     <= 1'b0;
            code_acc  <= '0;
            any_acc   <= 1'b0;
            multi_acc <= 1'b0;
            out_valid <= 1'b0;
            out_code  <= '0;
            out_any   <= 1'b0;
            out_multi <= 1'b0;
        end else begin
            state     <= state_d;
            word      <= word_d;
            msb_q     <= msb_d;
            cnt       <= cnt_d;
            found     <= found_d;
            code_acc  <= code_d;
            any_acc   <= any_d;
            multi_acc <= multi_d;
            out_valid <= out_valid_d;
            out_code  <= out_code_d;
            out_any   <= out_any_d;
            out_multi <= out_multi_d;
        end
    end

    always_comb begin
        state_d     = state;
        word_d      = word;
        msb_d       = msb_q;
        cnt_d       = cnt;
        found_d     = found;
        code_d      = code_acc;
        any_d       = any_acc;
        multi_d     = multi_acc;
        out_valid_d = out_valid;
        out_code_d  = out_code;
        out_any_d   = out_any;
        out_multi_d = out_multi;

        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    word_d  = in_data;
                    msb_d   = msb_first;
                    cnt_d   = '0;
                    found_d = 1'b0;
                    code_d  = '0;
                    any_d   = 1'b0;
                    multi_d = 1'b0;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                // Only the first nonzero slice visited sets the code.
                if (!found && nz_c) code_d = win_code_c;
                found_d = found | nz_c;
                any_d   = any_acc | nz_c;
                multi_d = multi_acc | smulti_c | (found & nz_c);
                if (cnt == CNT_W'(NSLICE - 1)) begin
                    out_code_d  = code_d;
                    out_any_d   = any_d;
                    out_multi_d = multi_d;
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_seq_priority_encoder.sv
// Bench for seq_priority_encoder: 32/8 instance via scoreboard, 8/8 instance directly.
module tb_seq_priority_encoder;

    typedef struct {
        logic [4:0] code;
        logic       any;
        logic       multi;
    } exp_t;

    typedef struct {
        logic [31:0] data;
        logic        msb;
        exp_t        e;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_in_valid = 1'b0, a_in_ready, a_msb = 1'b0;
    logic [31:0] a_in_data = '0;
    logic        a_out_valid, a_out_ready = 1'b1, a_out_any, a_out_multi;
    logic [4:0]  a_out_code;

    logic        b_in_valid = 1'b0, b_in_ready, b_msb = 1'b0;
    logic [7:0]  b_in_data = '0;
    logic        b_out_valid, b_out_any, b_out_multi;
    logic        b_out_ready = 1'b1;
    logic [2:0]  b_out_code;

    seq_priority_encoder #(.DATA_W(32), .SLICE_W(8)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .msb_first(a_msb),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_code(a_out_code), .out_any(a_out_any), .out_multi(a_out_multi)
    );

    seq_priority_encoder #(.DATA_W(8), .SLICE_W(8)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .msb_first(b_msb),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_code(b_out_code), .out_any(b_out_any), .out_multi(b_out_multi)
    );

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[10];

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bit-level reference, independent of slicing.
    function automatic exp_t model(input logic [31:0] d, input logic m);
        exp_t e;
        e.code  = '0;
        e.any   = |d;
        e.multi = $countones(d) > 1;
        if (m) begin
            for (int i = 0; i < 32; i++) if (d[i]) e.code = 5'(i);
        end else begin
            for (int i = 31; i >= 0; i--) if (d[i]) e.code = 5'(i);
        end
        return e;
    endfunction

    // Scoreboard: compare on every completed output handshake.
    always @(negedge clk) begin
        if (a_out_valid && a_out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("code",  32'(a_out_code),  32'(mon_e.code));
                chk("any",   32'(a_out_any),   32'(mon_e.any));
                chk("multi", 32'(a_out_multi), 32'(mon_e.multi));
            end
        end
    end

    task automatic wait_ready_a(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (a_in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("in_ready_timeout", 0, 1);
    endtask

    task automatic send_a(input logic [31:0] d, input logic m, input exp_t e);
        bit ok;
        int lat;
        wait_ready_a(ok);
        if (!ok) return;
        a_in_data  = d;
        a_msb      = m;
        a_in_valid = 1'b1;
        @(posedge clk);
        sb.push_back(e);
        #1;
        a_in_valid = 1'b0;
        a_in_data  = ~d;
        a_msb      = ~m;
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (a_out_valid) begin
                lat = i;
                break;
            end
        end
        chk("latency_a", 32'(lat), 4);
    endtask

    task automatic send_b(input logic [7:0] d, input logic m, input int unsigned code,
                          input logic any, input logic multi);
        int lat;
        for (int i = 0; i < 20 && !b_in_ready; i++) @(negedge clk);
        @(negedge clk);
        b_in_data  = d;
        b_msb      = m;
        b_in_valid = 1'b1;
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        b_in_data  = ~d;
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (b_out_valid) begin
                lat = i;
                break;
            end
        end
        chk("latency_b", 32'(lat), 1);
        chk("code_b",  32'(b_out_code), code);
        chk("any_b",   32'(b_out_any),  32'(any));
        chk("multi_b", 32'(b_out_multi), 32'(multi));
    endtask

    initial begin
        logic [31:0] d;
        logic        m;
        logic [7:0]  oh;
        bit          ok;

        vecs[0] = '{32'h0000_0001, 1'b0, '{5'd0,  1'b1, 1'b0}};
        vecs[1] = '{32'h8000_0001, 1'b1, '{5'd31, 1'b1, 1'b1}};
        vecs[2] = '{32'h8000_0001, 1'b0, '{5'd0,  1'b1, 1'b1}};
        vecs[3] = '{32'h0001_8000, 1'b0, '{5'd15, 1'b1, 1'b1}};
        vecs[4] = '{32'h0000_0000, 1'b1, '{5'd0,  1'b0, 1'b0}};
        vecs[5] = '{32'h0000_0300, 1'b1, '{5'd9,  1'b1, 1'b1}};
        vecs[6] = '{32'h0000_0300, 1'b0, '{5'd8,  1'b1, 1'b0 | 1'b1}};
        vecs[7] = '{32'h0400_0000, 1'b0, '{5'd26, 1'b1, 1'b0}};
        vecs[8] = '{32'h00F0_0000, 1'b1, '{5'd23, 1'b1, 1'b1}};
        vecs[9] = '{32'h0100_0080, 1'b0, '{5'd7,  1'b1, 1'b1}};

        // Reset: two cycles high.
        repeat (2) begin
            @(negedge clk);
            chk("rst_in_ready",  32'(a_in_ready), 0);
            chk("rst_out_valid", 32'(a_out_valid), 0);
            chk("rst_out_code",  32'(a_out_code), 0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(a_in_ready), 1);

        foreach (vecs[i]) send_a(vecs[i].data, vecs[i].msb, vecs[i].e);

        for (int i = 0; i < 8; i++) begin
            d = (i < 4) ? ($urandom & $urandom & $urandom) : $urandom;
            m = 1'($urandom_range(0, 1));
            send_a(d, m, model(d, m));
        end

        // Backpressure with an ignored in_valid pulse while DONE.
        @(negedge clk);
        a_out_ready = 1'b0;
        send_a(32'h0000_4000, 1'b1, '{5'd14, 1'b1, 1'b0});
        for (int c = 0; c < 3; c++) begin
            if (c == 1) begin
                a_in_valid = 1'b1;
                a_in_data  = 32'h0000_FFFF;
                a_msb      = 1'b0;
            end
            @(posedge clk);
            #1 a_in_valid = 1'b0;
            @(negedge clk);
            chk("bp_out_valid", 32'(a_out_valid), 1);
            chk("bp_out_code",  32'(a_out_code), 14);
            chk("bp_in_ready",  32'(a_in_ready), 0);
        end
        @(posedge clk);
        #1 a_out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_after_valid", 32'(a_out_valid), 0);
        chk("bp_after_ready", 32'(a_in_ready), 1);
        send_a(32'h0000_0020, 1'b0, '{5'd5, 1'b1, 1'b0});

        // Reset two cycles after accept drops the transaction.
        wait_ready_a(ok);
        a_in_data  = 32'h0010_0000;
        a_msb      = 1'b1;
        a_in_valid = 1'b1;
        @(posedge clk);
        #1 a_in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", 32'(a_in_ready), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_ready_after", 32'(a_in_ready), 1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("midrst_no_valid", 32'(a_out_valid), 0);
        end
        send_a(32'h0010_0000, 1'b1, '{5'd20, 1'b1, 1'b0});

        // 8-bit instance: one-hot walk, single-cycle latency.
        for (int i = 0; i < 8; i++) begin
            oh = 8'd1 << i;
            send_b(oh, 1'(i), i, 1'b1, 1'b0);
        end
        send_b(8'hA5, 1'b1, 7, 1'b1, 1'b1);
        send_b(8'hA4, 1'b0, 2, 1'b1, 1'b1);
        send_b(8'h00, 1'b1, 0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
